// File: rtl/iram_pkg.sv
// Shared types, constants and helpers for the internal data RAM access controller.
package iram_pkg;

  localparam int IRAM_ADDR_W = 7;
  localparam int IRAM_DATA_W = 8;
  localparam logic [IRAM_ADDR_W-1:0] IRAM_BIT_BASE = 7'h20;

  typedef enum logic [2:0] {
    RD   = 3'd0,
    WR   = 3'd1,
    BSET = 3'd2,
    BCLR = 3'd3,
    BCPL = 3'd4,
    BRD  = 3'd5
  } iram_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WBACK  = 2'd2,
    RESP   = 2'd3
  } iram_state_e;

  // Byte holding a bit address; upper bit-address nibble offsets from the base, wrapping
  function automatic logic [IRAM_ADDR_W-1:0] bit_byte_addr(input logic [IRAM_ADDR_W-1:0] base,
                                                           input logic [3:0] byte_sel);
    return base + {3'b000, byte_sel};
  endfunction

  function automatic logic is_bit_modify(input iram_op_e op);
    return (op == BSET) || (op == BCLR) || (op == BCPL);
  endfunction

endpackage

// File: rtl/iram_access_ctrl_if.sv
// CPU request/response handshake plus RAM port of the internal data RAM controller.
interface iram_access_ctrl_if import iram_pkg::*; #(
  parameter int ADDR_W = IRAM_ADDR_W,
  parameter int DATA_W = IRAM_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_bit;
  logic              ram_en;
  logic              read_en;
  logic              write_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, data_out,
    output req_ready, rsp_valid, rsp_data, rsp_bit, ram_en, read_en, write_en, addr, data_in
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, data_out,
    input  req_ready, rsp_valid, rsp_data, rsp_bit, ram_en, read_en, write_en, addr, data_in
  );
endinterface

// File: rtl/iram_bit_alu.sv
// Combinational bit modify for the read-modify-write bit ops: set/clear/invert one bit
// and report that bit's value before modification.
module iram_bit_alu import iram_pkg::*; #(
  parameter int DATA_W = IRAM_DATA_W
) (
  input  logic [DATA_W-1:0] byte_in,
  input  logic [2:0]        bit_idx,
  input  iram_op_e          op,
  output logic [DATA_W-1:0] byte_out,
  output logic              bit_out
);
  logic [DATA_W-1:0] mask_s;

  // Non-bit ops pass the byte through unchanged
  always_comb begin
    mask_s  = {{(DATA_W-1){1'b0}}, 1'b1} << bit_idx;
    bit_out = byte_in[bit_idx];
    case (op)
      BSET:    byte_out = byte_in | mask_s;
      BCLR:    byte_out = byte_in & ~mask_s;
      BCPL:    byte_out = byte_in ^ mask_s;
      default: byte_out = byte_in;
    endcase
  end
endmodule

// File: rtl/iram_access_ctrl.sv
// Initiator for the 128-byte internal data RAM: byte reads/writes and read-modify-write bit ops.
// IRAM_FAST_RSP_EN: RD/WR/BRD respond straight out of ACCESS (1-cycle latency).
module iram_access_ctrl import iram_pkg::*; #(
  parameter int                     ADDR_W   = IRAM_ADDR_W,
  parameter int                     DATA_W   = IRAM_DATA_W,
  parameter logic [IRAM_ADDR_W-1:0] BIT_BASE = IRAM_BIT_BASE
) (
  input logic                clk,
  input logic                rst,
  iram_access_ctrl_if.slave  bus
);
  iram_state_e       state_r;
  iram_op_e          op_r;
  iram_op_e          req_op_s;
  logic [2:0]        bit_idx_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rd_q_r;
  logic              rd_bit_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              rsp_bit_r;
  logic              ram_en_r;
  logic              read_en_r;
  logic              write_en_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_in_r;
  logic [ADDR_W-1:0] target_s;
  logic [DATA_W-1:0] alu_byte_s;
  logic              alu_bit_s;
  logic [DATA_W-1:0] rsp_now_data_s;
  logic              rsp_now_bit_s;

  iram_bit_alu #(.DATA_W(DATA_W)) u_bit_alu (
    .byte_in  (bus.data_out),
    .bit_idx  (bit_idx_r),
    .op       (op_r),
    .byte_out (alu_byte_s),
    .bit_out  (alu_bit_s)
  );

  // Decode the request: unknown op codes degrade to RD, bit ops map to their byte
  always_comb begin
    case (bus.req_op)
      3'd1:    req_op_s = WR;
      3'd2:    req_op_s = BSET;
      3'd3:    req_op_s = BCLR;
      3'd4:    req_op_s = BCPL;
      3'd5:    req_op_s = BRD;
      default: req_op_s = RD;
    endcase
    if (is_bit_modify(req_op_s) || (req_op_s == BRD)) begin
      target_s = bit_byte_addr(BIT_BASE, bus.req_addr[6:3]);
    end else begin
      target_s = bus.req_addr;
    end
    rsp_now_data_s = (op_r == WR) ? wdata_r : bus.data_out;
    rsp_now_bit_s  = (op_r == BRD) ? alu_bit_s : 1'b0;
  end

  // Request/response FSM; RAM strobes and response fields are all registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      op_r        <= RD;
      bit_idx_r   <= 3'd0;
      wdata_r     <= {DATA_W{1'b0}};
      rd_q_r      <= {DATA_W{1'b0}};
      rd_bit_r    <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_bit_r   <= 1'b0;
      ram_en_r    <= 1'b0;
      read_en_r   <= 1'b0;
      write_en_r  <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      data_in_r   <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            op_r        <= req_op_s;
            bit_idx_r   <= bus.req_addr[2:0];
            wdata_r     <= bus.req_wdata;
            addr_r      <= target_s;
            data_in_r   <= bus.req_wdata;
            ram_en_r    <= 1'b1;
            read_en_r   <= (req_op_s != WR);
            write_en_r  <= (req_op_s == WR);
            req_ready_r <= 1'b0;
            state_r     <= ACCESS;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ACCESS: begin
          rd_q_r    <= bus.data_out;
          rd_bit_r  <= alu_bit_s;
          read_en_r <= 1'b0;
          if (is_bit_modify(op_r)) begin
            write_en_r <= 1'b1;
            data_in_r  <= alu_byte_s;
            state_r    <= WBACK;
          end else begin
            ram_en_r   <= 1'b0;
            write_en_r <= 1'b0;
            rsp_data_r <= rsp_now_data_s;
            rsp_bit_r  <= rsp_now_bit_s;
`ifdef IRAM_FAST_RSP_EN
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
`else
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
`endif
          end
        end
        WBACK: begin
          ram_en_r    <= 1'b0;
          write_en_r  <= 1'b0;
          rsp_valid_r <= 1'b1;
          rsp_data_r  <= rd_q_r;
          rsp_bit_r   <= rd_bit_r;
          state_r     <= RESP;
        end
        RESP: begin
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          ram_en_r    <= 1'b0;
          read_en_r   <= 1'b0;
          write_en_r  <= 1'b0;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.ram_en    = ram_en_r;
  assign bus.read_en   = read_en_r;
  assign bus.write_en  = write_en_r;
  assign bus.addr      = addr_r;
  assign bus.data_in   = data_in_r;

`ifdef IRAM_FAST_RSP_EN
  logic fast_rsp_s;

  // Byte ops answer during ACCESS with the RAM's combinational read data
  always_comb begin
    fast_rsp_s = (state_r == ACCESS) && !is_bit_modify(op_r);
    if (fast_rsp_s) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = rsp_now_data_s;
      bus.rsp_bit   = rsp_now_bit_s;
    end else begin
      bus.rsp_valid = rsp_valid_r;
      bus.rsp_data  = rsp_data_r;
      bus.rsp_bit   = rsp_bit_r;
    end
  end
`else
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_bit   = rsp_bit_r;
`endif
endmodule
